// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, decode_stage and execute.
// slave: the decode stage's view; master: the upstream/downstream driver's view.
interface decode_stage_if #(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned EXTRA_W  = 4,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned DATA_W   = 32
);
    logic                i_flush;
    logic                i_valid;
    logic                o_ready;
    logic [INSTR_W-1:0]  i_instruction;
    logic                o_valid;
    logic                i_ready;
    logic [OPCODE_W-1:0] o_opcode;
    logic [EXTRA_W-1:0]  o_extra;
    logic [REG_W-1:0]    o_operandA;
    logic [REG_W-1:0]    o_operandB;
    logic [DATA_W-1:0]   o_immediate;
    logic                o_illegal;
    logic [31:0]         o_count;
    logic [15:0]         o_illegal_count;

    modport slave (
        input  i_flush, i_valid, i_instruction, i_ready,
        output o_ready, o_valid, o_opcode, o_extra, o_operandA, o_operandB,
        output o_immediate, o_illegal, o_count, o_illegal_count
    );

    modport master (
        output i_flush, i_valid, i_instruction, i_ready,
        input  o_ready, o_valid, o_opcode, o_extra, o_operandA, o_operandB,
        input  o_immediate, o_illegal, o_count, o_illegal_count
    );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode stage with a 2-entry skid buffer (OUT + SKID).
// Define DECODE_STATS_EN to build the emitted/illegal entry counters.
module decode_stage #(
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned EXTRA_W  = 4,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned DATA_W   = 32,
    parameter logic [(1<<OPCODE_W)-1:0] SEXT_MASK  = '0,
    parameter logic [(1<<OPCODE_W)-1:0] LEGAL_MASK = '1
) (
    input logic            clk,
    input logic            reset,
    decode_stage_if.slave  bus
);

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [EXTRA_W-1:0]  extra;
        logic [REG_W-1:0]    op_a;
        logic [REG_W-1:0]    op_b;
        logic [DATA_W-1:0]   imm;
        logic                illegal;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    function automatic entry_t decode(input logic [INSTR_W-1:0] ins);
        entry_t             e;
        logic [IMM_W-1:0]   imm;
        logic [DATA_W-1:0]  ext;
        e.opcode = ins[INSTR_W-1 -: OPCODE_W];
        e.extra  = ins[INSTR_W-OPCODE_W-1 -: EXTRA_W];
        e.op_a   = ins[INSTR_W-OPCODE_W-EXTRA_W-1 -: REG_W];
        e.op_b   = ins[IMM_W+REG_W-1 -: REG_W];
        imm      = ins[IMM_W-1:0];
        // Fill with the sign (or zero), then overlay the raw field; works for DATA_W == IMM_W.
        ext              = {DATA_W{SEXT_MASK[e.opcode] & imm[IMM_W-1]}};
        ext[IMM_W-1:0]   = imm;
        e.imm            = ext;
        e.illegal        = ~LEGAL_MASK[e.opcode];
        return e;
    endfunction

    state_e state_q, state_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   valid_q, valid_d;
    logic   ready_q, ready_d;
    logic   accept, emit;
    entry_t incoming;

    assign accept   = bus.i_valid && ready_q;
    assign emit     = valid_q && bus.i_ready;
    assign incoming = decode(bus.i_instruction);

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (bus.i_flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        out_d   = incoming;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        out_d = incoming;
                    end else if (accept) begin
                        skid_d  = incoming;
                        state_d = StFull;
                    end else if (emit) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (emit) begin
                        out_d   = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        // Handshake outputs are registered so o_ready never sees i_ready combinationally.
        valid_d = (state_d != StEmpty);
        ready_d = (state_d != StFull);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
            out_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_ready     = ready_q;
    assign bus.o_opcode    = out_q.opcode;
    assign bus.o_extra     = out_q.extra;
    assign bus.o_operandA  = out_q.op_a;
    assign bus.o_operandB  = out_q.op_b;
    assign bus.o_immediate = out_q.imm;
    assign bus.o_illegal   = out_q.illegal;

`ifdef DECODE_STATS_EN
    logic [31:0] count_q, count_d;
    logic [15:0] icount_q, icount_d;

    always_comb begin
        count_d  = count_q;
        icount_d = icount_q;
        if (emit && !bus.i_flush) begin
            count_d = count_q + 32'd1;
            if (out_q.illegal && (icount_q != 16'hFFFF)) begin
                icount_d = icount_q + 16'd1;
            end
        end
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            icount_q <= '0;
        end else begin
            count_q  <= count_d;
            icount_q <= icount_d;
        end
    end

    assign bus.o_count         = count_q;
    assign bus.o_illegal_count = icount_q;
`else
    assign bus.o_count         = '0;
    assign bus.o_illegal_count = '0;
`endif

endmodule
